// File: rtl/vector_writeback_pkg.sv
// Shared vector-unit definitions.
//   VLEN / EA_W / VL_W : register geometry (64 elements, 6-bit address, 7-bit VL)
//   wb_state_t         : write-back sequencer state encoding
//   reg_onehot()       : destination register number -> one-hot reservation mask
package vector_writeback_pkg;

  localparam int VLEN = 64;
  localparam int EA_W = 6;
  localparam int VL_W = 7;
  localparam int NREG = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_WRITE = 2'd2
  } wb_state_t;

  function automatic logic [NREG-1:0] reg_onehot(input logic [2:0] r);
    return NREG'(1) << r;
  endfunction

endpackage

// File: rtl/vector_writeback.sv
// Vector result write-back sequencer.
// Captures one element per clock from a functional unit, LATENCY cycles after
// issue, and writes elements 0..vl_eff-1 into the destination V register.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   i_start/i_vl/i_i   issue pulse, vector length, destination register
//   i_result           element result stream
//   o_wr_en/reg/addr/data  V register file write port (registered)
//   o_vreg_busy        one-hot reservation of the destination register
//   o_chain_count      elements of the current operation already written
//   o_busy, o_done     operation in progress / final-write pulse
module vector_writeback
  import vector_writeback_pkg::*;
#(
  parameter int LATENCY = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [VL_W-1:0]  i_vl,
  input  logic [2:0]       i_i,
  input  logic [63:0]      i_result,
  output logic             o_wr_en,
  output logic [2:0]       o_wr_reg,
  output logic [EA_W-1:0]  o_wr_addr,
  output logic [63:0]      o_wr_data,
  output logic [NREG-1:0]  o_vreg_busy,
  output logic [VL_W-1:0]  o_chain_count,
  output logic             o_busy,
  output logic             o_done
);

  wb_state_t       state;
  logic [3:0]      dly_cnt;
  logic [VL_W-1:0] vl_q;

  logic [VL_W-1:0] vl_eff;
  logic [VL_W-1:0] addr_ext;
  logic            last_elem;
  logic            next_last;

  assign vl_eff    = (i_vl > VL_W'(VLEN)) ? VL_W'(VLEN) : i_vl;
  assign addr_ext  = {1'b0, o_wr_addr};
  // o_wr_addr doubles as the element counter: it names the element on the port now.
  assign last_elem = (addr_ext == vl_q - VL_W'(1));
  // The element captured this cycle (addr+1) will be the final one.
  assign next_last = (addr_ext + VL_W'(1) == vl_q - VL_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      dly_cnt       <= '0;
      vl_q          <= '0;
      o_wr_en       <= 1'b0;
      o_wr_reg      <= '0;
      o_wr_addr     <= '0;
      o_wr_data     <= '0;
      o_vreg_busy   <= '0;
      o_chain_count <= '0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
    end else begin
      o_done <= 1'b0;
      // Chain count trails the write port by one cycle.
      if (o_wr_en) o_chain_count <= o_chain_count + VL_W'(1);

      case (state)
        ST_IDLE: begin
          if (i_start) begin
            vl_q          <= vl_eff;
            dly_cnt       <= 4'(LATENCY);
            o_wr_addr     <= '0;
            o_chain_count <= '0;
            // Zero-length ops are accepted but produce nothing and reserve nothing.
            if (vl_eff != '0) begin
              state       <= ST_WAIT;
              o_busy      <= 1'b1;
              o_wr_reg    <= i_i;
              o_vreg_busy <= reg_onehot(i_i);
            end
          end
        end

        ST_WAIT: begin
          if (dly_cnt == 4'd1) begin
            o_wr_en   <= 1'b1;
            o_wr_addr <= '0;
            o_wr_data <= i_result;
            o_done    <= (vl_q == VL_W'(1));
            state     <= ST_WRITE;
          end else begin
            dly_cnt <= dly_cnt - 4'd1;
          end
        end

        ST_WRITE: begin
          if (last_elem) begin
            o_wr_en     <= 1'b0;
            o_busy      <= 1'b0;
            o_wr_reg    <= '0;
            o_vreg_busy <= '0;
            state       <= ST_IDLE;
          end else begin
            o_wr_addr <= o_wr_addr + EA_W'(1);
            o_wr_data <= i_result;
            o_done    <= next_last;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_writeback.sv
// Bench for vector_writeback: cycle-by-cycle comparison against a timeline
// model derived from issue cycle, length and destination of each accepted op.
module tb_vector_writeback;
  import vector_writeback_pkg::*;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_start = 1'b0;
  logic [6:0]  i_vl = '0;
  logic [2:0]  i_i = '0;
  logic [63:0] i_result = '0;
  logic        o_wr_en;
  logic [2:0]  o_wr_reg;
  logic [5:0]  o_wr_addr;
  logic [63:0] o_wr_data;
  logic [7:0]  o_vreg_busy;
  logic [6:0]  o_chain_count;
  logic        o_busy;
  logic        o_done;

  always #5 clk = ~clk;

  vector_writeback #(.LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_vl(i_vl), .i_i(i_i),
    .i_result(i_result), .o_wr_en(o_wr_en), .o_wr_reg(o_wr_reg),
    .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data), .o_vreg_busy(o_vreg_busy),
    .o_chain_count(o_chain_count), .o_busy(o_busy), .o_done(o_done)
  );

  typedef struct packed {
    logic        en;
    logic [2:0]  wreg;
    logic [5:0]  addr;
    logic [63:0] data;
    logic [7:0]  vb;
    logic [6:0]  cc;
    logic        busy;
    logic        done;
  } obs_t;

  typedef struct {
    int         s;
    int         vl;
    logic [2:0] dest;
  } op_t;

  op_t         ops[$];
  logic [63:0] rlog[int];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  // Expected outputs at cycle c from the most recent accepted op.
  function automatic obs_t exp_at(input int c);
    obs_t e = '0;
    int   k = -1, t, vl;
    foreach (ops[j]) if (ops[j].s < c) k = j;
    if (k < 0) return e;
    t  = c - ops[k].s;
    vl = ops[k].vl;
    if (vl > 0 && t >= 1 && t <= LAT + vl) begin
      e.busy = 1'b1;
      e.wreg = ops[k].dest;
      e.vb   = 8'(1) << ops[k].dest;
    end
    if (vl > 0 && t >= LAT + 1 && t <= LAT + vl) begin
      e.en   = 1'b1;
      e.addr = 6'(t - LAT - 1);
      e.data = rlog[c-1];
    end
    e.done = (vl > 0 && t == LAT + vl);
    e.cc   = (t <= LAT + 1) ? 7'd0 : 7'(((t - LAT - 1) < vl) ? (t - LAT - 1) : vl);
    return e;
  endfunction

  // addr/data are only meaningful while a write is expected.
  function automatic obs_t observe(input logic keep);
    obs_t o;
    o = '{o_wr_en, o_wr_reg, o_wr_addr, o_wr_data, o_vreg_busy, o_chain_count, o_busy, o_done};
    if (!keep) begin o.addr = '0; o.data = '0; end
    return o;
  endfunction

  task automatic drive(input logic st, input int vl, input logic [2:0] d,
                       input logic r, input logic [63:0] res);
    i_start  = st;
    i_vl     = 7'(vl);
    i_i      = d;
    rst      = r;
    i_result = res;
    rlog[cyc] = res;
    if (r) ops.delete();
    else if (st && !exp_at(cyc).busy) ops.push_back('{cyc, (vl > 64) ? 64 : vl, d});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic test_reset();
    obs_t o;
    for (int t = 0; t < 3; t++) begin
      drive(1'b0, 0, 3'd0, 1'b1, rnd64());
      tick();
    end
    o = observe(1'b1);
    checks++;
    if (o !== obs_t'('0)) begin
      errors++;
      $display("FAIL reset_state got=%h exp=0", o);
    end
    drive(1'b0, 0, 3'd0, 1'b0, rnd64());
    tick();
  endtask

  task automatic test_basic();
    obs_t e, o;
    int   nw = 0;
    for (int t = 0; t < 12; t++) begin
      drive(t == 0, 5, 3'd2, 1'b0, 64'(100 + t - LAT));
      tick();
      e = exp_at(cyc); o = observe(e.en); checks++;
      if (o !== e) begin errors++; $display("FAIL basic cyc=%0d got=%h exp=%h", cyc, o, e); end
      if (o_wr_en) nw++;
    end
    checks++;
    if (nw != 5) begin errors++; $display("FAIL basic_count got=%0d exp=5", nw); end
  endtask

  task automatic test_full(input int vl);
    obs_t e, o;
    int   nw = 0;
    for (int t = 0; t < 72; t++) begin
      drive(t == 0, vl, 3'd6, 1'b0, rnd64());
      tick();
      e = exp_at(cyc); o = observe(e.en); checks++;
      if (o !== e) begin errors++; $display("FAIL full_vl%0d cyc=%0d got=%h exp=%h", vl, cyc, o, e); end
      if (o_wr_en) nw++;
    end
    checks++;
    if (nw != 64 || o_chain_count !== 7'd64) begin
      errors++;
      $display("FAIL full_count vl=%0d got=%0d/%0d exp=64/64", vl, nw, o_chain_count);
    end
  endtask

  task automatic test_zero();
    obs_t e, o;
    int   act = 0;
    for (int t = 0; t < 8; t++) begin
      drive(t == 0, 0, 3'd5, 1'b0, rnd64());
      tick();
      e = exp_at(cyc); o = observe(e.en); checks++;
      if (o !== e) begin errors++; $display("FAIL zero cyc=%0d got=%h exp=%h", cyc, o, e); end
      if (o_wr_en || o_done || o_busy || o_vreg_busy != 0) act++;
    end
    checks++;
    if (act != 0) begin errors++; $display("FAIL zero_activity got=%0d exp=0", act); end
  endtask

  task automatic test_restart();
    obs_t e, o;
    int   nw1 = 0, nw5 = 0;
    for (int t = 0; t < 16; t++) begin
      if (t == 4) drive(1'b1, 3, 3'd5, 1'b0, rnd64());
      else        drive(t == 0, 8, 3'd1, 1'b0, rnd64());
      tick();
      e = exp_at(cyc); o = observe(e.en); checks++;
      if (o !== e) begin errors++; $display("FAIL restart cyc=%0d got=%h exp=%h", cyc, o, e); end
      if (o_wr_en && o_wr_reg == 3'd1) nw1++;
      if (o_wr_en && o_wr_reg == 3'd5) nw5++;
    end
    checks++;
    if (nw1 != 8 || nw5 != 0) begin
      errors++;
      $display("FAIL restart_count got=%0d/%0d exp=8/0", nw1, nw5);
    end
  endtask

  task automatic test_reset_mid();
    obs_t e, o;
    int   late = 0;
    for (int t = 0; t < 16; t++) begin
      drive(t == 0, 20, 3'd7, t == 10, rnd64());
      tick();
      e = exp_at(cyc); o = observe(e.en); checks++;
      if (o !== e) begin errors++; $display("FAIL reset_mid cyc=%0d got=%h exp=%h", cyc, o, e); end
      if (t >= 10 && (o_wr_en || o_busy || o_wr_addr != 0 || o_wr_data != 0)) late++;
    end
    checks++;
    if (late != 0) begin errors++; $display("FAIL reset_mid_quiet got=%0d exp=0", late); end
    test_basic();
  endtask

  task automatic test_back_to_back();
    obs_t e, o;
    for (int t = 0; t < 14; t++) begin
      if (t == 6) drive(1'b1, 1, 3'd4, 1'b0, rnd64());
      else        drive(t == 0, 2, 3'd3, 1'b0, rnd64());
      tick();
      e = exp_at(cyc); o = observe(e.en); checks++;
      if (o !== e) begin errors++; $display("FAIL b2b cyc=%0d got=%h exp=%h", cyc, o, e); end
      if (t + 1 == 10) begin
        checks++;
        if (!(o_wr_en && o_wr_reg == 3'd4 && o_wr_addr == 6'd0)) begin
          errors++;
          $display("FAIL b2b_second got=%b/%0d/%0d exp=1/4/0", o_wr_en, o_wr_reg, o_wr_addr);
        end
      end
    end
  endtask

  task automatic test_random();
    obs_t e, o;
    int   vl, svl, gap;
    logic [2:0] d, sd;
    logic spur;
    for (int n = 0; n < 12; n++) begin
      vl   = $urandom_range(0, 90);
      d    = 3'($urandom);
      svl  = $urandom_range(0, 90);
      sd   = 3'($urandom);
      spur = 1'($urandom);
      gap  = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        drive(1'b0, 0, 3'd0, 1'b0, rnd64());
        tick();
      end
      for (int t = 0; t < 200; t++) begin
        if (t == 2) drive(spur, svl, sd, 1'b0, rnd64());
        else        drive(t == 0, vl, d, 1'b0, rnd64());
        tick();
        e = exp_at(cyc); o = observe(e.en); checks++;
        if (o !== e) begin errors++; $display("FAIL random op=%0d cyc=%0d got=%h exp=%h", n, cyc, o, e); end
        if (t >= 2 && !e.busy) break;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full(64);
    test_full(100);
    test_zero();
    test_restart();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vector_writeback.md
# vector_writeback

Result write-back sequencer downstream of the vector functional units (add, logical, shift). It captures the stream of element results a unit produces, one per clock after the unit's fixed functional time, and writes them into the destination V register at ascending element addresses 0..VL-1. It reserves the destination register for the operation's duration. It also publishes per-element progress so issue logic can chain a dependent vector operation off the destination register.

## Interface
- LATENCY, 3: cycles from the `i_start` cycle to the cycle element 0 is valid on `i_result`; legal range 1..15.
- VLEN, 64: elements per V register; element address width is 6.
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- i_start  input  1  one-cycle pulse issuing an operation; sampled with `i_vl`, `i_i`.
- i_vl  input  7  vector length for this operation.
- i_i  input  3  destination V register number.
- i_result  input  64  element result stream from the functional unit.
- o_wr_en  output  1  write strobe to the V register file.
- o_wr_reg  output  3  destination register for the write.
- o_wr_addr  output  6  element address for the write.
- o_wr_data  output  64  element data for the write.
- o_vreg_busy  output  8  one-hot reservation of the destination register.
- o_chain_count  output  7  number of elements of the current operation already written.
- o_busy  output  1  operation in progress; a new `i_start` is ignored while high.
- o_done  output  1  one-cycle pulse coincident with the final write.

## Operation
- States: IDLE, WAIT, WRITE.
- IDLE with `i_start`:
  - Latch `vl_eff = min(i_vl, 64)` and `i_i`.
  - Load the delay counter with LATENCY.
  - Clear the element counter and `o_chain_count`.
  - If `vl_eff == 0`, stay in IDLE: no writes, no reservation, no `o_done`.
  - Otherwise go to WAIT.
- WAIT: decrement the delay counter each cycle. When it reaches 1, capture `i_result` as element 0 and go to WRITE.
- WRITE: each cycle, drive the previously captured element onto the write port and capture the next `i_result`. After writing element `vl_eff-1`, return to IDLE and ignore further `i_result` values.
- `i_start` in WAIT or WRITE is ignored: no restart, no state change. Issue logic must honour `o_busy`.
- `o_wr_reg` holds the latched destination throughout the operation. It is 0 in IDLE.
- `o_wr_addr` equals the element counter, increments by 1 per write, and never wraps within an operation because `vl_eff` ≤ 64.
- `o_wr_data` is registered and holds its last value when `o_wr_en` is low.
- `o_vreg_busy[dest]` is high from the cycle after `i_start` through the cycle of the final write, and low otherwise.
- `o_chain_count` increments in the cycle after each write. It equals `vl_eff` after completion and holds until the next accepted `i_start`.
- Reset mid-operation aborts immediately. No further writes occur and the element counter is discarded.

## Timing
- Cycle 0 = the cycle `i_start` is high.
- Element k is valid on `i_result` at cycle LATENCY+k. It is written with `o_wr_en=1`, `o_wr_addr=k` at cycle LATENCY+k+1.
- The final write, together with the `o_done` pulse, is at cycle LATENCY+vl_eff. `o_busy` falls in the cycle after that.
- `o_busy` is high in cycles 1..LATENCY+vl_eff inclusive.
- The earliest accepted back-to-back `i_start` is at cycle LATENCY+vl_eff+1.
- All outputs are registered. Reset values: `o_wr_en=0`, `o_wr_reg=0`, `o_wr_addr=0`, `o_wr_data=0`, `o_vreg_busy=0`, `o_chain_count=0`, `o_busy=0`, `o_done=0`, state IDLE.

## Structure
- The shared vector package holds:
  - `VLEN` (64).
  - Element-address width (6) and VL width (7).
  - The IDLE/WAIT/WRITE state encoding.
  - The one-hot register-select helper, reused by other reservation logic.
- Single module, no sub-modules.
- The delay counter and the element counter are two small counters inside this block.

## Test plan
- Basic: LATENCY=3, `i_vl=5`, `i_i=2`, drive `i_result=100+k` at cycle 3+k. Expect:
  - Writes at cycles 4..8 with addr 0..4 and data 100..104.
  - `o_wr_reg=2` on every write.
  - `o_done` at cycle 8, `o_busy` high for cycles 1..8.
  - `o_vreg_busy=8'h04` for cycles 1..8.
- Full and clamped length: `i_vl=64`, then `i_vl=100`. Each produces exactly 64 writes with addr 0..63, last at cycle 67. `o_chain_count` ends at 64.
- Zero length: `i_vl=0`. Expect no `o_wr_en`, no `o_done`, and `o_busy` and `o_vreg_busy` stay 0.
- Ignored restart: while busy from `i_vl=8`, `i_i=1`, pulse `i_start` with `i_vl=3`, `i_i=5` at cycle 4. Expect the 8 original writes to reg 1 to be unaffected and no writes to reg 5.
- Reset mid-op: `i_vl=20`, assert `rst` at cycle 10. From cycle 11, all outputs are at reset values and no writes occur. A fresh `i_start` afterwards behaves as in the basic test.
- Back-to-back: `i_vl=2`, `i_i=3`, then `i_start` at cycle 6 with `i_vl=1`, `i_i=4`. Expect:
  - Writes at cycles 4 and 5 to reg 3, then a write at cycle 10 to reg 4, addr 0.
  - `o_chain_count` resets to 0 at cycle 7.
